// File: rtl/alu_result_writeback_if.sv
// alu_result_writeback_if: capture side (opcode, zin, res_valid/res_ready), write-back side (bus_out, wb_valid/wb_ready, wb_sel), done and flag_z/flag_n; slave = writeback unit, master = control/destination
interface alu_result_writeback_if #(parameter int DATA_W = 32);
  logic [4:0] opcode;
  logic [2*DATA_W-1:0] zin;
  logic res_valid, res_ready;
  logic [DATA_W-1:0] bus_out;
  logic wb_valid, wb_ready;
  logic [1:0] wb_sel;
  logic done, flag_z, flag_n;
  modport master(output opcode, zin, res_valid, wb_ready, input res_ready, bus_out, wb_valid, wb_sel, done, flag_z, flag_n);
  modport slave(input opcode, zin, res_valid, wb_ready, output res_ready, bus_out, wb_valid, wb_sel, done, flag_z, flag_n);
endinterface

// File: rtl/alu_result_writeback.sv
// alu_result_writeback: captures 2*DATA_W ALU result on res_valid/res_ready, writes it back as one Rz word or LO then HI (MUL/DIV) over bus_out/wb_valid/wb_ready/wb_sel, pulses done; ports clock, reset (sync active-high), bus (slave); flag_z/flag_n live only with ALU_RESULT_FLAGS_EN
module alu_result_writeback #(parameter int DATA_W = 32) (
  input logic clock,
  input logic reset,
  alu_result_writeback_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WB_ONE, WB_LO, WB_HI, DONE} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] zhi, zlo;
  logic cap, is_two, is_one;
  assign cap = state == IDLE && bus.res_valid;
  assign is_two = bus.opcode inside {5'b01111, 5'b00001};
  assign is_one = bus.opcode inside {5'b01100, 5'b01010, 5'b01011, 5'b10010, 5'b10001, 5'b01000,
                                     5'b01001, 5'b00111, 5'b00101, 5'b00110, 5'b00100};
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      zhi <= '0;
      zlo <= '0;
    end else begin
      state <= state_nx;
      if (cap) {zhi, zlo} <= bus.zin;
    end
  end
  always_comb begin
    state_nx = state == IDLE   ? (bus.res_valid ? (is_two ? WB_LO : is_one ? WB_ONE : DONE) : IDLE) :
               state == WB_ONE ? (bus.wb_ready ? DONE : WB_ONE) :
               state == WB_LO  ? (bus.wb_ready ? WB_HI : WB_LO) :
               state == WB_HI  ? (bus.wb_ready ? DONE : WB_HI) : IDLE;
    bus.res_ready = state == IDLE;
    bus.done = state == DONE;
    bus.wb_valid = state inside {WB_ONE, WB_LO, WB_HI};
    bus.wb_sel = state == WB_ONE ? 2'b01 : state == WB_LO ? 2'b10 : state == WB_HI ? 2'b11 : 2'b00;
    bus.bus_out = state inside {WB_ONE, WB_LO} ? zlo : state == WB_HI ? zhi : '0;
  end
`ifdef ALU_RESULT_FLAGS_EN
  logic fz, fn;
  always_ff @(posedge clock) begin
    if (reset) begin
      fz <= 1'b0;
      fn <= 1'b0;
    end else if (cap) begin
      fz <= is_two ? bus.zin == '0 : is_one && bus.zin[DATA_W-1:0] == '0;
      fn <= is_two ? bus.zin[2*DATA_W-1] : is_one && bus.zin[DATA_W-1];
    end
  end
  assign bus.flag_z = fz;
  assign bus.flag_n = fn;
`else
  assign bus.flag_z = 1'b0;
  assign bus.flag_n = 1'b0;
`endif
endmodule

// File: tb/tb_alu_result_writeback.sv
// tb_alu_result_writeback: randomized + directed scoreboard bench for alu_result_writeback
module tb_alu_result_writeback;
  logic clock = 1'b0;
  logic reset = 1'b1;
  alu_result_writeback_if #(.DATA_W(32)) bus();
  alu_result_writeback #(.DATA_W(32)) dut(.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  typedef struct {bit is_done; logic [1:0] sel; logic [31:0] data; int cap; int nw; bit fz; bit fn;} item_t;
  item_t q[$];
  int vecs = 0, errs = 0, cyc = 0, hold = 0, stalls = 0;
  bit rnd = 0, prev_stall = 0, prev_done = 0;
  logic [1:0] psel;
  logic [31:0] pbus;
  logic [4:0] ops[13] = '{5'b01111, 5'b00001, 5'b01100, 5'b01010, 5'b01011, 5'b10010, 5'b10001,
                          5'b01000, 5'b01001, 5'b00111, 5'b00101, 5'b00110, 5'b00100};
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic int words(logic [4:0] opc);
    if (opc inside {5'b01111, 5'b00001}) return 2;
    if (opc inside {5'b01100, 5'b01010, 5'b01011, 5'b10010, 5'b10001, 5'b01000,
                    5'b01001, 5'b00111, 5'b00101, 5'b00110, 5'b00100}) return 1;
    return 0;
  endfunction
  always @(posedge clock) cyc++;
  always @(posedge clock) begin
    #2;
    if (hold > 0) begin
      bus.wb_ready = 1'b0;
      hold--;
    end else bus.wb_ready = rnd ? ($urandom % 3 != 0) : 1'b1;
  end
  always @(negedge clock) begin
    item_t it;
    if (reset) begin
      q.delete();
      stalls = 0;
      prev_stall = 0;
      prev_done = 0;
    end else begin
      if (prev_done) chk("ready_after_done", bus.res_ready, 1);
      if (prev_stall) chk("stall_hold", {bus.wb_valid, bus.wb_sel, bus.bus_out}, {1'b1, psel, pbus});
      if (!bus.wb_valid) chk("idle_bus", {bus.wb_sel, bus.bus_out}, 0);
      if (bus.wb_valid && bus.wb_ready) begin
        if (q.size() == 0) chk("unexpected_word", 1, 0);
        else begin
          it = q.pop_front();
          chk("wb_kind", it.is_done, 0);
          chk("wb_sel", bus.wb_sel, it.sel);
          chk("wb_data", bus.bus_out, it.data);
        end
      end
      if (bus.done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          it = q.pop_front();
          chk("done_kind", it.is_done, 1);
          chk("done_cycle", cyc, it.cap + it.nw + stalls);
          chk("flags", {bus.flag_z, bus.flag_n}, {it.fz, it.fn});
        end
        stalls = 0;
      end
      if (bus.wb_valid && !bus.wb_ready) stalls++;
      prev_stall = bus.wb_valid && !bus.wb_ready;
      prev_done = bus.done;
      psel = bus.wb_sel;
      pbus = bus.bus_out;
    end
  end
  task automatic issue(logic [4:0] opc, logic [63:0] z, int h);
    int n = words(opc);
    int t = 0;
    item_t it;
    forever begin
      @(negedge clock);
      if (bus.res_ready) break;
      if (++t > 60) begin
        chk("ready_timeout", 0, 1);
        return;
      end
    end
    bus.opcode = opc;
    bus.zin = z;
    bus.res_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.res_valid = 1'b0;
    bus.opcode = 5'($urandom);
    bus.zin = {$urandom, $urandom};
    if (h > 0) hold = h;
    it = '{is_done: 0, sel: (n == 2) ? 2'b10 : 2'b01, data: z[31:0], cap: cyc, nw: n, fz: 0, fn: 0};
    if (n >= 1) q.push_back(it);
    if (n == 2) begin
      it.sel = 2'b11;
      it.data = z[63:32];
      q.push_back(it);
    end
    it.is_done = 1;
`ifdef ALU_RESULT_FLAGS_EN
    it.fz = n == 2 ? z == 0 : n == 1 ? z[31:0] == 0 : 1'b0;
    it.fn = n == 2 ? z[63] : n == 1 ? z[31] : 1'b0;
`endif
    q.push_back(it);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [4:0] opc;
    logic [63:0] z;
    int t;
    bus.res_valid = 1'b0;
    bus.opcode = '0;
    bus.zin = '0;
    bus.wb_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_state", {bus.res_ready, bus.wb_valid, bus.wb_sel, bus.bus_out, bus.done, bus.flag_z, bus.flag_n},
        {1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0});
    @(posedge clock);
    #1 reset = 1'b0;
    issue(5'b01100, 64'h7, 0);
    issue(5'b01111, 64'h0000_0001_8000_0000, 0);
    issue(5'b00001, 64'h1234_5678_9abc_def0, 3);
    issue(5'b11111, 64'hdead_beef_0000_0001, 0);
    issue(5'b01111, 64'h0000_0002_0000_0003, 0);
    @(negedge clock);
    @(negedge clock);
    chk("hi_phase", bus.wb_sel, 2'b11);
    bus.opcode = 5'b01100;
    bus.zin = 64'h55;
    bus.res_valid = 1'b1;
    @(posedge clock);
    #1 bus.res_valid = 1'b0;
    issue(5'b00100, 64'h0000_0000_ffff_ffff, 0);
    issue(5'b01010, 64'hffff_ffff_0000_0000, 0);
    issue(5'b00001, 64'h1111_2222_3333_4444, 10);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    hold = 0;
    @(negedge clock);
    chk("reset_mid_wb", {bus.res_ready, bus.wb_valid, bus.wb_sel, bus.bus_out, bus.flag_z, bus.flag_n},
        {1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0});
    issue(5'b00101, 64'h0, 0);
    rnd = 1;
    repeat (40) begin
      opc = ($urandom % 4 == 0) ? 5'($urandom) : ops[$urandom % 13];
      case ($urandom % 5)
        0: z = 64'h0;
        1: z = {$urandom, 32'h0};
        default: z = {$urandom, $urandom};
      endcase
      issue(opc, z, 0);
    end
    rnd = 0;
    t = 0;
    while ((q.size() != 0 || !bus.res_ready) && t < 200) begin
      @(negedge clock);
      t++;
    end
    chk("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
